// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 9-bit-instruction datapath.
// Optional retired-instruction counter enabled by INSTR_COUNT_EN.
module instr_sequencer #(
    parameter int NREG = 8,
    parameter int IR_W = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [IR_W-1:0] din,
    output logic [NREG-1:0] r_in,
    output logic            a_in,
    output logic            g_in,
    output logic            ir_in,
    output logic [3:0]      bus_sel,
    output logic            add_sub,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [15:0]     instr_count
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] SEL_G   = 4'd8;
    localparam logic [3:0] SEL_DIN = 4'd9;

    state_t            state_q;
    state_t            state_d;
    logic [IR_W-1:0]   ir_q;
    logic [2:0]        op;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [NREG-1:0]   rx_hot;

    assign op = ir_q[8:6];
    assign rx = ir_q[5:3];
    assign ry = ir_q[2:0];
    assign rx_hot = {{(NREG-1){1'b0}}, 1'b1} << rx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T0 && run)
                ir_q <= din;
        end
    end

    always_comb begin
        state_d = state_q;
        r_in    = '0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        ir_in   = 1'b0;
        bus_sel = 4'd0;
        add_sub = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        busy    = (state_q != T0);
        unique case (state_q)
            T0: begin
                // gated so the strobe stays low while reset is held
                ir_in = run & rst;
                if (run)
                    state_d = T1;
            end
            T1: begin
                unique case (op)
                    3'b000: begin
                        bus_sel = {1'b0, ry};
                        r_in    = rx_hot;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    3'b001: begin
                        bus_sel = SEL_DIN;
                        r_in    = rx_hot;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    3'b010, 3'b011: begin
                        bus_sel = {1'b0, rx};
                        a_in    = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        illegal = 1'b1;
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                bus_sel = {1'b0, ry};
                g_in    = 1'b1;
                add_sub = op[0];
                state_d = T3;
            end
            T3: begin
                bus_sel = SEL_G;
                r_in    = rx_hot;
                done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (done && !illegal)
            cnt_q <= cnt_q + 16'd1;
    end

    assign instr_count = cnt_q;
`else
    assign instr_count = 16'd0;
`endif

endmodule
